sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO; next generation of the team's 4x8 FIFO.
- Generalised in data width and depth; uses all DEPTH entries via an extra pointer wrap bit (no wasted slot).
- Adds occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, and overflow/underflow error pulses.
- Sits between producer/consumer blocks in the same clock domain.

---
 rtl/fifo_pkg.sv | 38 +++
 rtl/sync_fifo_param_mem.sv | 40 ++++
 rtl/sync_fifo_param.sv | 119 +++++++++++
 tb/tb_sync_fifo_param.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
//============================================================================
// Package     : fifo_pkg
// Description : Shared helpers for the parametrised synchronous FIFO:
//               constant log2, power-of-two test and threshold legality.
// Revision    : 1.0 - initial release
//============================================================================
package fifo_pkg;

    // Smallest n such that 2**n >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // True for powers of two of at least 2 (the pointer wrap-bit scheme needs it).
    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    // Thresholds must lie inside the range count can actually take.
    function automatic bit levels_in_range(input int depth, input int af_lvl, input int ae_lvl);
        return (af_lvl >= 1) && (af_lvl <= depth) && (ae_lvl >= 0) && (ae_lvl < depth);
    endfunction

    // Overlapping almost-empty/almost-full bands are legal but rarely intended.
    function automatic bit levels_ordered(input int af_lvl, input int ae_lvl);
        return ae_lvl < af_lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_param_mem.sv
`default_nettype none
//============================================================================
// Module      : fifo_mem
// Description : Simple dual-port register array. Synchronous write,
//               combinational read. Contents are never reset.
// Revision    : 1.0 - initial release
//============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // One register per entry, each loaded only when its address is written.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(g))) begin
                    r_mem[g] <= wdata;
                end
            end
        end
    endgenerate

    // Read path is a plain mux; the top level registers the result.
    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
//============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO. All DEPTH entries are used by
//               carrying an extra wrap bit on each pointer. Provides count,
//               programmable almost-full/empty flags, a read-valid strobe and
//               one-cycle overflow/underflow error pulses.
// Revision    : 1.0 - initial release
//============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    parameter  int AF_LVL = DEPTH - 1,
    parameter  int AE_LVL = 1,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              wr_err,
    output logic              rd_err
);

    localparam logic [AW:0] c_af_lvl  = (AW + 1)'(AF_LVL);
    localparam logic [AW:0] c_ae_lvl  = (AW + 1)'(AE_LVL);
    localparam logic [AW:0] c_ptr_one = (AW + 1)'(1);

    // Elaboration-time legality checks on the parameter set.
    generate
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two >= 2");
        end
        if (!levels_in_range(DEPTH, AF_LVL, AE_LVL)) begin : g_bad_levels
            $error("sync_fifo_param: AF_LVL must be 1..DEPTH and AE_LVL 0..DEPTH-1");
        end
        if (!levels_ordered(AF_LVL, AE_LVL)) begin : g_overlap_levels
            $warning("sync_fifo_param: AE_LVL >= AF_LVL, almost flags overlap");
        end
    endgenerate

    logic [AW:0]       r_w_ptr;
    logic [AW:0]       r_r_ptr;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic [DATA_W-1:0] w_mem_rdata;

    // Occupancy and flags derive only from the registered pointers, so they
    // change in the cycle after the edge that moved a pointer.
    assign count        = r_w_ptr - r_r_ptr;
    assign empty        = (r_w_ptr == r_r_ptr);
    assign full         = (r_w_ptr[AW] != r_r_ptr[AW]) &&
                          (r_w_ptr[AW-1:0] == r_r_ptr[AW-1:0]);
    assign almost_full  = (count >= c_af_lvl);
    assign almost_empty = (count <= c_ae_lvl);

    // A request is honoured only if the FIFO state allows it; a write at full
    // is dropped even when a read frees a slot on the same edge, and a read at
    // empty never falls through a concurrent write.
    assign w_wr_accept = wr_en && !full;
    assign w_rd_accept = rd_en && !empty;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (w_wr_accept),
        .waddr  (r_w_ptr[AW-1:0]),
        .wdata  (data_in),
        .raddr  (r_r_ptr[AW-1:0]),
        .rdata  (w_mem_rdata)
    );

    // Write pointer: advances on every accepted write, wraps modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w_ptr <= '0;
        end else if (w_wr_accept) begin
            r_w_ptr <= r_w_ptr + c_ptr_one;
        end
    end

    // Read pointer and output register: data_out holds between accepted reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_r_ptr  <= '0;
            data_out <= '0;
        end else if (w_rd_accept) begin
            r_r_ptr  <= r_r_ptr + c_ptr_one;
            data_out <= w_mem_rdata;
        end
    end

    // Single-cycle status strobes for the edge just taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= w_rd_accept;
            wr_err   <= wr_en && full;
            rd_err   <= rd_en && empty;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
//============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench. Two FIFO configurations (4x8 default and
//               16x16 with AF=12/AE=3) share one stimulus stream; each is
//               compared every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_sync_fifo_param;

    localparam int DA  = 4;
    localparam int DB  = 16;
    localparam int AFA = 3;
    localparam int AEA = 1;
    localparam int AFB = 12;
    localparam int AEB = 3;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] din   = '0;

    logic [7:0]  a_dout;
    logic        a_rv, a_full, a_empty, a_af, a_ae, a_werr, a_rerr;
    logic [2:0]  a_cnt;
    logic [15:0] b_dout;
    logic        b_rv, b_full, b_empty, b_af, b_ae, b_werr, b_rerr;
    logic [4:0]  b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: queue contents and expected registered outputs.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] e_dout [2];
    bit          e_rv   [2];
    bit          e_werr [2];
    bit          e_rerr [2];

    always #5 clk = ~clk;

    sync_fifo_param u_dut_a (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .data_in      (din[7:0]),
        .rd_en        (rd_en),
        .data_out     (a_dout),
        .rd_valid     (a_rv),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_af),
        .almost_empty (a_ae),
        .count        (a_cnt),
        .wr_err       (a_werr),
        .rd_err       (a_rerr)
    );

    sync_fifo_param #(
        .DATA_W (16),
        .DEPTH  (DB),
        .AF_LVL (AFB),
        .AE_LVL (AEB)
    ) u_dut_b (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .data_in      (din),
        .rd_en        (rd_en),
        .data_out     (b_dout),
        .rd_valid     (b_rv),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_af),
        .almost_empty (b_ae),
        .count        (b_cnt),
        .wr_err       (b_werr),
        .rd_err       (b_rerr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        for (int k = 0; k < 2; k++) begin
            e_dout[k] = '0;
            e_rv[k]   = 1'b0;
            e_werr[k] = 1'b0;
            e_rerr[k] = 1'b0;
        end
    endtask

    // Apply one clock edge of FIFO semantics to both models (pre-edge state decides).
    task automatic model_edge(input bit w, input bit r, input logic [15:0] d);
        bit wa, ra;
        wa = w && (qa.size() < DA);
        ra = r && (qa.size() > 0);
        e_werr[0] = w && (qa.size() == DA);
        e_rerr[0] = r && (qa.size() == 0);
        e_rv[0]   = ra;
        if (ra) e_dout[0] = qa.pop_front();
        if (wa) qa.push_back({8'h00, d[7:0]});

        wa = w && (qb.size() < DB);
        ra = r && (qb.size() > 0);
        e_werr[1] = w && (qb.size() == DB);
        e_rerr[1] = r && (qb.size() == 0);
        e_rv[1]   = ra;
        if (ra) e_dout[1] = qb.pop_front();
        if (wa) qb.push_back(d);
    endtask

    task automatic check_all();
        chk("a_count",    32'(a_cnt),   qa.size());
        chk("a_empty",    32'(a_empty), 32'(qa.size() == 0));
        chk("a_full",     32'(a_full),  32'(qa.size() == DA));
        chk("a_afull",    32'(a_af),    32'(qa.size() >= AFA));
        chk("a_aempty",   32'(a_ae),    32'(qa.size() <= AEA));
        chk("a_rd_valid", 32'(a_rv),    32'(e_rv[0]));
        chk("a_data_out", 32'(a_dout),  32'(e_dout[0]));
        chk("a_wr_err",   32'(a_werr),  32'(e_werr[0]));
        chk("a_rd_err",   32'(a_rerr),  32'(e_rerr[0]));
        chk("b_count",    32'(b_cnt),   qb.size());
        chk("b_empty",    32'(b_empty), 32'(qb.size() == 0));
        chk("b_full",     32'(b_full),  32'(qb.size() == DB));
        chk("b_afull",    32'(b_af),    32'(qb.size() >= AFB));
        chk("b_aempty",   32'(b_ae),    32'(qb.size() <= AEB));
        chk("b_rd_valid", 32'(b_rv),    32'(e_rv[1]));
        chk("b_data_out", 32'(b_dout),  32'(e_dout[1]));
        chk("b_wr_err",   32'(b_werr),  32'(e_werr[1]));
        chk("b_rd_err",   32'(b_rerr),  32'(e_rerr[1]));
    endtask

    // One cycle: drive on the falling edge, model the rising edge, sample 1ns later.
    task automatic step(input bit w, input bit r, input logic [15:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        model_edge(w, r, d);
        #1;
        check_all();
    endtask

    // Reset dropped between edges; outputs must clear without waiting for clk.
    task automatic reset_async();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, '0);
        #2;
        rstn = 1'b0;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int wp, rp;
        model_clear();
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0, '0);
        step(0, 0, '0);

        // Fill to full, then one write too many.
        step(1, 0, 16'h0011);
        step(1, 0, 16'h0022);
        step(1, 0, 16'h0033);
        step(1, 0, 16'h0044);
        step(1, 0, 16'h0055);
        step(0, 0, '0);

        // Drain, plus one read too many.
        for (int i = 0; i < 5; i++) step(0, 1, '0);
        step(0, 1, '0);
        step(0, 0, '0);

        // Steady stream at count 2 across several pointer wraps.
        step(1, 0, 16'h0060);
        step(1, 0, 16'h0061);
        for (int i = 0; i < 20; i++) step(1, 1, 16'(16'h0062 + i));

        // Full with simultaneous read/write: the write must be dropped.
        step(1, 0, 16'h0080);
        step(1, 0, 16'h0081);
        step(1, 1, 16'h00AA);
        for (int i = 0; i < 4; i++) step(0, 1, '0);

        // Reset with data in flight, then a fresh write lands at entry 0.
        step(1, 0, 16'h0001);
        step(1, 0, 16'h0002);
        step(1, 0, 16'h0003);
        reset_async();
        step(1, 0, 16'h005A);
        step(0, 1, '0);
        step(0, 0, '0);

        // Randomized traffic in write-heavy, read-heavy and balanced phases.
        for (int ph = 0; ph < 3; ph++) begin
            wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            rp = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
            for (int i = 0; i < 200; i++) begin
                if (ph == 2 && i == 100) reset_async();
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 16'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
